fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter N, default 64, SHALL set the PC/address width in bits.
REQ-002 Parameter IW, default 32, SHALL set the instruction width in bits.
REQ-003 Parameter DEPTH, default 4, SHALL set the prefetch queue depth; power of two, >=2.
REQ-004 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-006 reset  in  1  SHALL be the reset, asynchronous and active-low.
REQ-007 PCSrc_F  in  1  SHALL be the redirect request (taken branch/jump).
REQ-008 PCbranch_F  in  N  SHALL be the redirect target address.
REQ-009 imem_addr_F  out  N  SHALL be the current fetch address (the PC register).
REQ-010 imem_data_F  in  IW  SHALL be the instruction at imem_addr_F, valid combinationally in the same cycle.
REQ-011 out_valid  out  1  SHALL flag that the queue head is valid.
REQ-012 out_ready  in  1  SHALL flag that decode accepts the head this cycle.
REQ-013 out_pc  out  N  SHALL be the PC of the queue head.
REQ-014 out_instr  out  IW  SHALL be the instruction of the queue head.
REQ-015 count  out  $clog2(DEPTH)+1  SHALL be the number of valid queue entries.

Function
REQ-016 out_valid SHALL equal (count != 0); out_pc/out_instr SHALL come from the head entry with no combinational path from imem_data_F.
REQ-017 Pop SHALL occur when out_valid && out_ready && !PCSrc_F.
REQ-018 Push SHALL occur when !PCSrc_F && (count < DEPTH || pop); push stores {imem_addr_F, imem_data_F} at the tail.
REQ-019 On push, PC SHALL advance to PC+4 modulo 2^N; wrap from 2^N-4 to 0 is legal and silent.
REQ-020 With no push and no redirect (full, no pop), PC SHALL hold.
REQ-021 Simultaneous push and pop on a full queue SHALL keep count at DEPTH and advance PC.
REQ-022 Simultaneous push and pop on an empty queue is impossible (pop requires out_valid); push alone SHALL make count 1.
REQ-023 PCSrc_F=1 SHALL take priority: next cycle PC = {PCbranch_F[N-1:2], 2'b00}, count = 0, pointers cleared, no push, no pop.
REQ-024 Push latency SHALL be one cycle: an instruction fetched at edge k is visible at the head no earlier than after edge k.
REQ-025 Entries SHALL leave the queue in program (push) order.

Reset
REQ-026 While reset=0: PC=RESET_PC (so imem_addr_F=RESET_PC), count=0, head/tail pointers=0, out_valid=0.
REQ-027 Assertion mid-operation SHALL discard all entries immediately, independent of clk.
REQ-028 First push SHALL occur at the first rising edge after reset deasserts.

Structure
REQ-029 Package fetch_pkg SHALL hold INSTR_BYTES=4, the default RESET_PC, and the PC-alignment mask helper constant.
REQ-030 Queue storage SHALL be one sub-module, fetch_fifo (parametrised width/DEPTH, with synchronous flush and asynchronous active-low reset); PC logic stays in fetch_queue.

Verification (DEPTH=4, N=64 unless stated)
REQ-031 Reset release, out_ready=1 always -> out_valid=1 after first edge; out_pc = 0,4,8,12,... one per cycle; count stays 1.
REQ-032 out_ready=0 after reset -> 4 pushes, count=4, imem_addr_F holds 16; then out_ready=1 one cycle -> pop pc 0 and push pc 16 same edge, count=4, PC=20.
REQ-033 PCSrc_F=1, PCbranch_F=457515 while count=3 -> next cycle count=0, out_valid=0, imem_addr_F=457512; following edge pushes pc 457512.
REQ-034 PCSrc_F=1 with full queue and out_ready=1 -> no pop seen (head not consumed), queue empty, PC=target.
REQ-035 N=16, RESET_PC=16'hFFFC, out_ready=1 -> out_pc = FFFC then 0000, 0004.
REQ-036 reset pulled low between edges with count=3 -> count=0, out_valid=0, imem_addr_F=RESET_PC immediately, before next clk edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch front end: instruction size,
// default reset PC and the mask that word-aligns redirect targets.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [63:0] DEFAULT_RESET_PC = '0;
  localparam logic [63:0] PC_ALIGN_MASK    = ~64'(INSTR_BYTES - 1);

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer: DEPTH entries of W bits, synchronous flush,
// asynchronous active-low reset of pointers and occupancy.
module fetch_fifo #(
  parameter int unsigned W     = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head_ptr;
  logic [AW-1:0] tail_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= din;
  end

  assign dout = mem[head_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: PC register plus a prefetch queue of {pc, instruction} pairs
// feeding decode; a redirect flushes the queue and reloads the PC.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned N        = 64,
  parameter int unsigned IW       = 32,
  parameter int unsigned DEPTH    = 4,
  parameter logic [N-1:0] RESET_PC = N'(DEFAULT_RESET_PC)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     PCSrc_F,
  input  logic [N-1:0]             PCbranch_F,
  output logic [N-1:0]             imem_addr_F,
  input  logic [IW-1:0]            imem_data_F,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_pc,
  output logic [IW-1:0]            out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [N-1:0]    pc;
  logic [N+IW-1:0] head;
  logic            full;
  logic            push;
  logic            pop;

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !PCSrc_F;
  // A pop frees a slot in the same edge, so a full queue can still accept.
  assign push      = !PCSrc_F && (!full || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        pc <= RESET_PC;
    else if (PCSrc_F)  pc <= PCbranch_F & PC_ALIGN_MASK[N-1:0];
    else if (push)     pc <= pc + N'(INSTR_BYTES);
  end

  assign imem_addr_F = pc;

  fetch_fifo #(
    .W     (N + IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (PCSrc_F),
    .push  (push),
    .pop   (pop),
    .din   ({imem_addr_F, imem_data_F}),
    .dout  (head),
    .count (count)
  );

  assign out_pc    = head[N+IW-1:IW];
  assign out_instr = head[IW-1:0];

endmodule
